// File: rtl/stepped_shift_unit_if.sv
// Handshake/bus bundle for stepped_shift_unit.
// Carries the button, mode/data inputs and register outputs.
interface stepped_shift_unit_if #(
    parameter int WIDTH = 8
);
    logic             step;
    logic [2:0]       M;
    logic             SI;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             SO;
    logic             shot;
    logic [7:0]       step_cnt;

    modport master (
        output step, M, SI, D,
        input  Q, SO, shot, step_cnt
    );

    modport slave (
        input  step, M, SI, D,
        output Q, SO, shot, step_cnt
    );
endinterface

// File: rtl/stepped_shift_unit.sv
// Push-button stepped shift register.
// Debounced button press executes one register operation.
module stepped_shift_unit #(
    parameter int WIDTH = 8,
    parameter int DIV   = 250000,
    parameter int DB_N  = 3
) (
    input logic                 clk_100MHZ,
    input logic                 reset,
    stepped_shift_unit_if.slave bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TMAX = CW'(DIV - 1);

    logic             s1, s2;
    logic [CW-1:0]    tcnt;
    logic             tick;
    logic [DB_N-1:0]  hist;
    logic [DB_N-1:0]  hist_next;
    logic             level;
    logic             level_next;
    logic             level_seen;
    logic             shot_r;
    logic [WIDTH-1:0] q_r;
    logic             so_r;
    logic [7:0]       cnt_r;

    assign tick      = (tcnt == TMAX);
    assign hist_next = {hist[DB_N-2:0], s2};

    // Two-flop synchronizer for the raw button
    always_ff @(posedge clk_100MHZ or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= bus.step;
            s2 <= s1;
        end
    end

    // Free-running sample-tick divider
    always_ff @(posedge clk_100MHZ or negedge reset) begin
        if (!reset)
            tcnt <= '0;
        else if (tick)
            tcnt <= '0;
        else
            tcnt <= tcnt + 1'b1;
    end

    // Level flips only on a unanimous sample window
    always_comb begin
        level_next = level;
        if (tick) begin
            if (&hist_next)
                level_next = 1'b1;
            else if (~|hist_next)
                level_next = 1'b0;
        end
    end

    // Sample history and debounced level
    always_ff @(posedge clk_100MHZ or negedge reset) begin
        if (!reset) begin
            hist  <= '0;
            level <= 1'b0;
        end else begin
            if (tick)
                hist <= hist_next;
            level <= level_next;
        end
    end

    // One-cycle strobe on the rising debounced edge
    always_ff @(posedge clk_100MHZ or negedge reset) begin
        if (!reset) begin
            level_seen <= 1'b0;
            shot_r     <= 1'b0;
        end else begin
            level_seen <= level;
            shot_r     <= level & ~level_seen;
        end
    end

    // Register operation and step count, once per shot
    always_ff @(posedge clk_100MHZ or negedge reset) begin
        if (!reset) begin
            q_r   <= '0;
            so_r  <= 1'b0;
            cnt_r <= '0;
        end else if (shot_r) begin
            cnt_r <= cnt_r + 8'd1;
            unique case (bus.M)
                3'b000: ;
                3'b001: begin
                    q_r  <= {bus.SI, q_r[WIDTH-1:1]};
                    so_r <= q_r[0];
                end
                3'b010: begin
                    q_r  <= {q_r[WIDTH-2:0], bus.SI};
                    so_r <= q_r[WIDTH-1];
                end
                3'b011: q_r <= bus.D;
                3'b100: begin
                    q_r  <= {q_r[0], q_r[WIDTH-1:1]};
                    so_r <= q_r[0];
                end
                3'b101: begin
                    q_r  <= {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    so_r <= q_r[WIDTH-1];
                end
                3'b110: begin
                    q_r  <= {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                    so_r <= q_r[0];
                end
                3'b111: q_r <= '0;
            endcase
        end
    end

    assign bus.Q        = q_r;
    assign bus.SO       = so_r;
    assign bus.shot     = shot_r;
    assign bus.step_cnt = cnt_r;
endmodule
